// File: rtl/wb_trap_pkg.sv
// Shared types and constants for the writeback / trap unit.
// Holds the FSM state enum, RISC-V opcodes, SYSTEM funct12 codes and cause values.
package wb_trap_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        REDIRECT = 2'd1,
        HALTED   = 2'd2
    } state_t;

    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [11:0] F12_ECALL = 12'h000;
    localparam logic [11:0] F12_MRET  = 12'h302;

    localparam int unsigned CAUSE_ECALL_M = 11;
    // Interrupt flag sits in the MSB of mcause (bit 31 for RV32).
    localparam int unsigned CAUSE_IRQ_BIT = 31;

    localparam int unsigned IRQ_IDX_W = 4;

endpackage

// File: rtl/writeback_trap_unit_irq.sv
// Interrupt pending latch: per-line edge/level capture plus lowest-index select.
// Ports: clk/rst, irq_in, mask_in, clear_in, pending_out, req_valid_out, req_idx_out.
module irq_pending_latch
    import wb_trap_pkg::*;
#(
    parameter int unsigned          NUM_IRQ       = 4,
    parameter logic [NUM_IRQ-1:0]   IRQ_EDGE_MASK = 4'b0011
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_IRQ-1:0]      irq_in,
    input  logic [NUM_IRQ-1:0]      mask_in,
    input  logic [NUM_IRQ-1:0]      clear_in,
    output logic [NUM_IRQ-1:0]      pending_out,
    output logic                    req_valid_out,
    output logic [IRQ_IDX_W-1:0]    req_idx_out
);

    logic [NUM_IRQ-1:0] prev_q;
    logic [NUM_IRQ-1:0] pending_q;
    logic [NUM_IRQ-1:0] pending_d;
    logic [NUM_IRQ-1:0] req;

    // A new edge in the same cycle as a clear wins, so it is not lost.
    always_comb begin
        pending_d = pending_q;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (IRQ_EDGE_MASK[i]) begin
                pending_d[i] = (pending_q[i] & ~clear_in[i])
                             | (irq_in[i] & ~prev_q[i]);
            end else begin
                pending_d[i] = irq_in[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q    <= '0;
            pending_q <= '0;
        end else begin
            prev_q    <= irq_in;
            pending_q <= pending_d;
        end
    end

    assign req = pending_q & mask_in;

    // Scan high to low so the lowest set index is the final assignment.
    always_comb begin
        req_valid_out = 1'b0;
        req_idx_out   = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                req_valid_out = 1'b1;
                req_idx_out   = IRQ_IDX_W'(i);
            end
        end
    end

    assign pending_out = pending_q;

endmodule

// File: rtl/writeback_trap_unit.sv
// Writeback stage with machine-mode trap handling (ECALL, MRET, interrupts, halt).
// Ports: retire inputs, irq lines/mask, rd forward, redirect pulse, CSR views, done.
module writeback_trap_unit
    import wb_trap_pkg::*;
#(
    parameter int unsigned          XLEN          = 32,
    parameter int unsigned          NUM_IRQ       = 4,
    parameter logic [NUM_IRQ-1:0]   IRQ_EDGE_MASK = 4'b0011,
    parameter logic [XLEN-1:0]      TRAP_VECTOR   = 32'h0000_0010,
    parameter logic [31:0]          HALT_WORD     = 32'h1111_1111
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic                stall_in,
    input  logic [31:0]         instr_in,
    input  logic [XLEN-1:0]     pc_in,
    input  logic [XLEN-1:0]     next_pc_in,
    input  logic [4:0]          rd_in,
    input  logic                rd_valid_in,
    input  logic [XLEN-1:0]     rd_data_in,
    input  logic [NUM_IRQ-1:0]  irq_in,
    input  logic [NUM_IRQ-1:0]  irq_mask_in,
    output logic                fwd_valid_out,
    output logic [4:0]          fwd_rd_out,
    output logic [XLEN-1:0]     fwd_data_out,
    output logic                redirect_valid_out,
    output logic [XLEN-1:0]     redirect_addr_out,
    output logic [XLEN-1:0]     mepc_out,
    output logic [XLEN-1:0]     mcause_out,
    output logic                mie_out,
    output logic [NUM_IRQ-1:0]  irq_pending_out,
    output logic                done_out
);

    state_t                 state_q;
    state_t                 state_d;
    logic [XLEN-1:0]        mepc_q;
    logic [XLEN-1:0]        mcause_q;
    logic [XLEN-1:0]        target_q;
    logic                   mie_q;
    logic                   mpie_q;

    logic                   retire;
    logic                   is_sys;
    logic                   is_ecall;
    logic                   is_mret;
    logic                   is_halt;
    logic                   suppress;
    logic                   take_irq;
    logic                   irq_valid;
    logic [IRQ_IDX_W-1:0]   irq_idx;
    logic [NUM_IRQ-1:0]     irq_clear;
    logic [XLEN-1:0]        irq_cause;

    assign is_sys   = instr_in[6:0] == OP_SYSTEM;
    assign is_ecall = is_sys && instr_in[31:20] == F12_ECALL;
    assign is_mret  = is_sys && instr_in[31:20] == F12_MRET;
    assign is_halt  = instr_in == HALT_WORD;
    assign retire   = in_valid && !stall_in && state_q == RUN;

    // Halt, ECALL and MRET never write rd, even if rd_valid_in is set.
    assign suppress = is_halt || is_ecall || is_mret;

    // Higher-priority events leave the interrupt pending for later.
    assign take_irq = retire && mie_q && irq_valid && !suppress;

    always_comb begin
        irq_clear = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            irq_clear[i] = take_irq && (irq_idx == IRQ_IDX_W'(i));
        end
    end

    always_comb begin
        irq_cause                            = '0;
        irq_cause[XLEN-1]                    = 1'b1;
        irq_cause[IRQ_IDX_W-1:0]             = irq_idx;
    end

    irq_pending_latch #(
        .NUM_IRQ       (NUM_IRQ),
        .IRQ_EDGE_MASK (IRQ_EDGE_MASK)
    ) u_irq (
        .clk           (clk),
        .rst           (rst),
        .irq_in        (irq_in),
        .mask_in       (irq_mask_in),
        .clear_in      (irq_clear),
        .pending_out   (irq_pending_out),
        .req_valid_out (irq_valid),
        .req_idx_out   (irq_idx)
    );

    assign fwd_valid_out = retire && rd_valid_in && rd_in != 5'd0 && !suppress;
    assign fwd_rd_out    = fwd_valid_out ? rd_in : 5'd0;
    assign fwd_data_out  = fwd_valid_out ? rd_data_in : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN: begin
                if (retire) begin
                    if (is_halt) begin
                        state_d = HALTED;
                    end else if (is_ecall || is_mret || take_irq) begin
                        state_d = REDIRECT;
                    end
                end
            end
            REDIRECT: state_d = RUN;
            HALTED:   state_d = HALTED;
            default:  state_d = RUN;
        endcase
    end

    always_comb begin
        redirect_valid_out = state_q == REDIRECT;
        redirect_addr_out  = redirect_valid_out ? target_q : '0;
        done_out           = state_q == HALTED;
    end

    // CSR and redirect target updates; MRET reads mepc before any change.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mepc_q   <= '0;
            mcause_q <= '0;
            target_q <= '0;
            mie_q    <= 1'b1;
            mpie_q   <= 1'b0;
        end else if (retire) begin
            unique case (1'b1)
                is_ecall: begin
                    mepc_q   <= pc_in;
                    mcause_q <= XLEN'(CAUSE_ECALL_M);
                    mpie_q   <= mie_q;
                    mie_q    <= 1'b0;
                    target_q <= TRAP_VECTOR;
                end
                is_mret: begin
                    mie_q    <= mpie_q;
                    mpie_q   <= 1'b1;
                    target_q <= mepc_q;
                end
                take_irq: begin
                    mepc_q   <= next_pc_in;
                    mcause_q <= irq_cause;
                    mpie_q   <= mie_q;
                    mie_q    <= 1'b0;
                    target_q <= TRAP_VECTOR;
                end
                default: begin
                end
            endcase
        end
    end

    assign mepc_out   = mepc_q;
    assign mcause_out = mcause_q;
    assign mie_out    = mie_q;

`ifdef WB_TRAP_TRACE
    always_ff @(posedge clk) begin
        if (retire && !is_halt) begin
            if (is_ecall || is_mret || take_irq) begin
                $display("[wb] trap pc=%h instr=%h irq=%0d", pc_in, instr_in, take_irq);
            end else begin
                $display("[wb] retire pc=%h instr=%h", pc_in, instr_in);
            end
        end
    end
`endif

endmodule
